// File: rtl/mips_cpu_load_store_unit_if.sv
// Bundles the CPU request/response handshake and the word-only data memory bus of the
// load/store unit. The LSU uses the slave modport; the CPU/memory side uses master.
interface mips_cpu_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rt_old, data_readdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output data_address, data_read, data_write, data_writedata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rt_old, data_readdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  data_address, data_read, data_write, data_writedata
    );
endinterface

// File: rtl/mips_cpu_load_store_unit.sv
// MIPS load/store unit: word-aligned memory access, sub-word loads with extension, RMW sub-word
// stores. Define MIPS_LSU_UNALIGNED_EN to make LWL/LWR legal; otherwise they report an error.
module mips_cpu_load_store_unit #(
    parameter logic [31:0] DATA_BASE  = 32'h00001000,
    parameter int unsigned DATA_WORDS = 32
) (
    input logic clk,
    input logic reset,
    mips_cpu_load_store_unit_if.slave bus
);
    localparam logic [31:0] DataEnd = DATA_BASE + 32'(4 * DATA_WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    localparam logic [3:0] OpLb  = 4'h0;
    localparam logic [3:0] OpLbu = 4'h1;
    localparam logic [3:0] OpLh  = 4'h2;
    localparam logic [3:0] OpLhu = 4'h3;
    localparam logic [3:0] OpLw  = 4'h4;
    localparam logic [3:0] OpLwl = 4'h5;
    localparam logic [3:0] OpLwr = 4'h6;
    localparam logic [3:0] OpSb  = 4'h8;
    localparam logic [3:0] OpSh  = 4'h9;
    localparam logic [3:0] OpSw  = 4'hA;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        op_ok, aligned, in_range;
    logic [1:0]  off;
    logic [4:0]  lane_sh;
    logic [31:0] mem_shr;

    // Request legality is decided on the live request fields in the accept cycle.
    always_comb begin
        op_ok   = 1'b0;
        aligned = 1'b1;
        unique case (bus.req_op)
            OpLb, OpLbu, OpLw, OpSb, OpSh, OpSw, OpLh, OpLhu: op_ok = 1'b1;
`ifdef MIPS_LSU_UNALIGNED_EN
            OpLwl, OpLwr: op_ok = 1'b1;
`endif
            default: op_ok = 1'b0;
        endcase
        case (bus.req_op)
            OpLh, OpLhu, OpSh: aligned = ~bus.req_addr[0];
            OpLw, OpSw:        aligned = (bus.req_addr[1:0] == 2'b00);
            default:           aligned = 1'b1;
        endcase
    end

    assign in_range = (bus.req_addr >= DATA_BASE) && (bus.req_addr < DataEnd);

    assign off     = addr_q[1:0];
    assign lane_sh = {off, 3'b000};
    assign mem_shr = bus.data_readdata >> lane_sh;

`ifdef MIPS_LSU_UNALIGNED_EN
    logic [31:0] rt_q, rt_d;
    logic [4:0]  lwl_sh;
    logic [31:0] lwl_res, lwr_res;

    assign lwl_sh  = {2'd3 - off, 3'b000};
    assign lwl_res = (bus.data_readdata << lwl_sh) | (rt_q & ((32'd1 << lwl_sh) - 32'd1));
    assign lwr_res = mem_shr | (rt_q & ~(32'hFFFF_FFFF >> lane_sh));
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MIPS_LSU_UNALIGNED_EN
        rt_d    = rt_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
`ifdef MIPS_LSU_UNALIGNED_EN
                    rt_d    = bus.req_rt_old;
`endif
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    if (!op_ok || !aligned || !in_range) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (bus.req_op == OpSw) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                state_d = StResp;
                case (op_q)
                    OpLb:  rdata_d = {{24{mem_shr[7]}}, mem_shr[7:0]};
                    OpLbu: rdata_d = {24'd0, mem_shr[7:0]};
                    OpLh:  rdata_d = {{16{mem_shr[15]}}, mem_shr[15:0]};
                    OpLhu: rdata_d = {16'd0, mem_shr[15:0]};
`ifdef MIPS_LSU_UNALIGNED_EN
                    OpLwl: rdata_d = lwl_res;
                    OpLwr: rdata_d = lwr_res;
`endif
                    // Sub-word stores merge into the word just read, then write it back.
                    OpSb: begin
                        wdata_d = (bus.data_readdata & ~(32'h0000_00FF << lane_sh))
                                | ({24'd0, wdata_q[7:0]} << lane_sh);
                        state_d = StWr;
                    end
                    OpSh: begin
                        wdata_d = (bus.data_readdata & ~(32'h0000_FFFF << lane_sh))
                                | ({16'd0, wdata_q[15:0]} << lane_sh);
                        state_d = StWr;
                    end
                    default: rdata_d = bus.data_readdata;
                endcase
            end
            StWr:    state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef MIPS_LSU_UNALIGNED_EN
            rt_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MIPS_LSU_UNALIGNED_EN
            rt_q    <= rt_d;
`endif
        end
    end

    always_comb begin
        bus.req_ready      = (state_q == StIdle);
        bus.resp_valid     = (state_q == StResp);
        bus.resp_rdata     = (state_q == StResp) ? rdata_q : 32'd0;
        bus.resp_error     = (state_q == StResp) & err_q;
        bus.data_read      = (state_q == StRd);
        bus.data_write     = (state_q == StWr);
        bus.data_address   = (state_q == StRd || state_q == StWr) ?
                             {addr_q[31:2], 2'b00} : 32'd0;
        bus.data_writedata = (state_q == StWr) ? wdata_q : 32'd0;
    end
endmodule

// File: doc/mips_cpu_load_store_unit.md
Name: mips_cpu_load_store_unit

Overview:
- Sits between the CPU memory-stage and the word-only data memory (base 0x00001000, combinational read, synchronous whole-word write).
- Turns CPU load/store requests into word-aligned memory accesses. Handles byte/halfword sign/zero extension on loads.
- Sub-word stores are done as read-modify-write (RMW) because the memory only writes full words.
- Checks alignment and reports misaligned or illegal requests as errors without touching memory.

Parameters:
- DATA_BASE, 32'h00001000, lowest legal data address; addresses below it are errors.
- DATA_WORDS, 32, number of data words; addresses at or above DATA_BASE+4*DATA_WORDS are errors.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset, synchronous to clk, active-low.
- req_valid  input  1  CPU request present.
- req_ready  output  1  high only in IDLE; a request is accepted on an edge where req_valid&&req_ready.
- req_op  input  4  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR 8=SB 9=SH A=SW; others are illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; sub-word data is in the low bits.
- req_rt_old  input  32  current rt value, used by LWL/LWR merge.
- resp_valid  output  1  one-cycle pulse; response complete.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_error  output  1  valid with resp_valid; misaligned, out-of-range or illegal op.
- data_address  output  32  word-aligned address to memory; addr[1:0] forced to 00.
- data_read  output  1  memory read strobe.
- data_write  output  1  memory write strobe.
- data_writedata  output  32  full word to write.
- data_readdata  input  32  memory read data, combinational.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State becomes IDLE.
  - Outputs: resp_valid=0, resp_rdata=0, resp_error=0, data_read=0, data_write=0, data_address=0, data_writedata=0.
  - Reset mid-operation abandons the request; no data_write occurs afterwards.
- All request fields are registered on acceptance. The CPU may change them afterwards.
- Byte order is little-endian: byte offset o=addr[1:0] maps to lane bits [8o+7:8o].
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1.
  - Illegal op, range error or misalignment → RESP with error=1. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Any load or SB/SH → RD.
  - SW → WR.
- RD: data_read=1 for exactly one cycle; data_readdata is sampled at the closing edge.
  - Load: compute result → RESP.
  - SB/SH: merge req_wdata into the sampled word at the addressed lane(s), keeping the other bytes → WR.
- WR: data_write=1 for exactly one cycle, data_writedata stable; memory updates at the closing edge → RESP.
- RESP: resp_valid=1 for one cycle; req_ready=0; → IDLE.
- Latencies (accept edge → resp_valid high): load 2 cycles; SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
- Back-to-back throughput is one request per 3/3/4/2 cycles respectively.
- Load extension:
  - LB: sign-extend byte o.
  - LBU: zero-extend byte o.
  - LH: sign-extend halfword at lanes o, o+1.
  - LHU: zero-extend halfword at lanes o, o+1.
  - LW: full word.
- data_read and data_write are never high in the same cycle.
- Outside RD and WR, data_read and data_write are 0.

Optional Feature:
- Macro: MIPS_LSU_UNALIGNED_EN.
- Defined: LWL/LWR are legal at any alignment and take the load path (2 cycles).
  - LWL result = (mem << 8*(3-o)) | (rt_old & ((1 << 8*(3-o)) - 1)).
  - LWR result = (mem >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
- Undefined: ops 5 and 6 are illegal → resp_error=1, no memory access, 1-cycle latency.

Test Plan:
- Sign vs zero extension: word at 0x1004 = 0x8899AABB.
  - LB 0x1005 → resp_rdata=0xFFFFFFAA, error=0, resp_valid 2 cycles after accept.
  - LBU 0x1005 → 0x000000AA.
- SB with RMW: word 0x1004=0x8899AABB; SB 0x1006, wdata=0x00000012.
  - Sequence is data_read one cycle, then data_write one cycle with data_writedata=0x8812AABB.
  - resp_valid 3 cycles after accept.
  - A following LW 0x1004 → 0x8812AABB.
- Misalignment and illegal op:
  - LH 0x1003 → resp_error=1, resp_rdata=0, 1-cycle latency, data_read and data_write never asserted.
  - Op 4'hF behaves the same way.
- Reset mid-RMW: SH 0x1008 wdata=0xBEEF, with reset low during the RD cycle.
  - No data_write is ever asserted; the word at 0x1008 is unchanged.
  - All outputs are 0 the cycle after; req_ready=1 once reset is released.
- LWL with MIPS_LSU_UNALIGNED_EN: mem 0x1004=0x8899AABB, rt_old=0x11223344, LWL 0x1005 → 0xAABB3344.
  - LWR 0x1005 → 0x118899AA.
  - Without the macro, both → resp_error=1.
- Back-to-back: SW 0x1000=0xDEADBEEF accepted in the RESP→IDLE cycle, then LW 0x1000 → 0xDEADBEEF.
  - req_ready low throughout the SW request, from the cycle after accept until IDLE.
